// File: rtl/bit4_bus_sink_pkg.sv
// Shared encodings for the 4-bit bus sink: destination select codes and FSM states.
package bit4_bus_sink_pkg;

  typedef enum logic [1:0] {
    DEST_LOAD_A = 2'b00,
    DEST_LOAD_B = 2'b01,
    DEST_ADD_A  = 2'b10,
    DEST_DROP   = 2'b11
  } dest_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ADD  = 1'b1
  } state_e;

endpackage

// File: rtl/bit4_bus_sink.sv
// Receiving end of the 4-bit shared bus: loads RegA/RegB, accumulates into RegA
// over two cycles, or drops the word, with a valid/ready handshake upstream.
module bit4_bus_sink
  import bit4_bus_sink_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] BusData,
  input  logic             BusValid,
  input  logic [1:0]       Dest,
  output logic             BusReady,
  output logic [WIDTH-1:0] RegA,
  output logic [WIDTH-1:0] RegB,
  output logic             Carry,
  output logic             Done,
  output logic [CNTW-1:0]  Count
);

  state_e            r_state;
  logic [WIDTH-1:0]  r_rega;
  logic [WIDTH-1:0]  r_regb;
  logic [WIDTH-1:0]  r_opnd;
  logic              r_carry;
  logic              r_done;
  logic [CNTW-1:0]   r_count;

  state_e            w_state_nxt;
  logic              w_done_nxt;
  logic              w_xfer;
  dest_e             w_dest;
  logic [WIDTH:0]    w_sum;

  assign BusReady = (r_state == S_IDLE);
  assign w_xfer   = BusValid && BusReady;
  assign w_dest   = dest_e'(Dest);
  assign w_sum    = {1'b0, r_rega} + {1'b0, r_opnd};

  // Done for an add is raised on the edge leaving ADD so it lands in the first IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_dest == DEST_ADD_A) begin
            w_state_nxt = S_ADD;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_ADD: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_rega  <= '0;
      r_regb  <= '0;
      r_opnd  <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_xfer) begin
        if (r_count != '1) begin
          r_count <= r_count + CNTW'(1);
        end
        case (w_dest)
          DEST_LOAD_A: r_rega <= BusData;
          DEST_LOAD_B: r_regb <= BusData;
          DEST_ADD_A:  r_opnd <= BusData;
          default:     ;
        endcase
      end
      if (r_state == S_ADD) begin
        {r_carry, r_rega} <= w_sum;
      end
    end
  end

  assign RegA  = r_rega;
  assign RegB  = r_regb;
  assign Carry = r_carry;
  assign Done  = r_done;
  assign Count = r_count;

endmodule

// File: tb/tb_bit4_bus_sink.sv
// Randomised scoreboard bench for bit4_bus_sink with directed reset/load/add/stall/saturation cases.
module tb_bit4_bus_sink;

  logic       Clock;
  logic       Resetn;
  logic [3:0] BusData;
  logic       BusValid;
  logic [1:0] Dest;
  logic       BusReady;
  logic [3:0] RegA;
  logic [3:0] RegB;
  logic       Carry;
  logic       Done;
  logic [7:0] Count;

  bit4_bus_sink #(.WIDTH(4), .CNTW(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .BusData(BusData), .BusValid(BusValid),
    .Dest(Dest), .BusReady(BusReady), .RegA(RegA), .RegB(RegB),
    .Carry(Carry), .Done(Done), .Count(Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: the architectural values after every accepted word.
  int   m_a, m_b, m_c, m_cnt;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int d, input int dst);
    exp_t e;
    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    case (dst)
      0: m_a = d;
      1: m_b = d;
      2: begin
        m_c = ((m_a + d) >= 16) ? 1 : 0;
        m_a = (m_a + d) % 16;
      end
      default: ;
    endcase
    e.a = 4'(m_a); e.b = 4'(m_b); e.c = m_c[0]; e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (Resetn && Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_rega",  RegA,  e.a);
        check("sb_regb",  RegB,  e.b);
        check("sb_carry", Carry, e.c);
        check("sb_count", Count, e.cnt);
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic [1:0] dst);
    int n = 0;
    @(negedge Clock);
    BusValid = 1'b1; BusData = d; Dest = dst;
    while (!BusReady && n < 10) begin
      @(negedge Clock);
      n++;
    end
    if (!BusReady) begin
      check("ready_timeout", 0, 1);
    end else begin
      model_accept(d, dst);
    end
    @(posedge Clock);
    #1;
    BusValid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge Clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge Clock);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(negedge Clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn = 1'b0; BusValid = 1'b0; BusData = '0; Dest = '0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    @(negedge Clock);
    check("rst_rega", RegA, 0);
    check("rst_regb", RegB, 0);
    check("rst_count", Count, 0);
    check("rst_carry", Carry, 0);
    check("rst_ready", BusReady, 1);
    check("rst_done", Done, 0);

    // Back-to-back loads
    send(4'hA, 2'b00);
    send(4'h3, 2'b01);
    check("load_done1", Done, 1);
    @(negedge Clock);
    check("load_done2", Done, 1);
    check("load_rega", RegA, 4'hA);
    check("load_regb", RegB, 4'h3);
    check("load_count", Count, 2);
    idle(1);

    // Add with wrap: 0xA + 0x9 = 0x13
    send(4'h9, 2'b10);
    check("add_ready_low", BusReady, 0);
    // Stall: word held valid during ADD must not be taken until IDLE
    BusValid = 1'b1; BusData = 4'h5; Dest = 2'b01;
    @(negedge Clock);
    check("stall_ready", BusReady, 0);
    check("stall_regb", RegB, 4'h3);
    check("stall_count", Count, 3);
    @(posedge Clock);
    #1;
    check("add_rega", RegA, 4'h3);
    check("add_carry", Carry, 1);
    check("add_done", Done, 1);
    send(4'h5, 2'b01);
    @(negedge Clock);
    check("stall_regb_after", RegB, 4'h5);
    check("stall_count_after", Count, 4);
    check("carry_sticky", Carry, 1);
    send(4'h2, 2'b00);
    @(negedge Clock);
    check("carry_kept_on_load", Carry, 1);
    drain();

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    drain();

    // Saturation via discards
    for (int i = 0; i < 260; i++) send(4'($urandom_range(0, 15)), 2'b11);
    drain();
    check("sat_count", Count, 255);
    check("sat_rega", RegA, m_a);
    check("sat_regb", RegB, m_b);
    send(4'h7, 2'b00);
    drain();
    check("sat_hold", Count, 255);

    // Reset mid-add
    send(4'hF, 2'b10);
    Resetn = 1'b0;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    model_reset();
    @(negedge Clock);
    check("mid_rst_rega", RegA, 0);
    check("mid_rst_carry", Carry, 0);
    check("mid_rst_ready", BusReady, 1);
    check("mid_rst_done", Done, 0);
    check("mid_rst_count", Count, 0);
    @(negedge Clock);
    check("mid_rst_done2", Done, 0);
    send(4'h6, 2'b10);
    drain();
    check("post_rst_add", RegA, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
